// File: rtl/alu_pipe_cc_if.sv
// Handshake and condition-code bundle for alu_pipe_cc.
// The master side offers operations and consumes results; the slave side is the ALU.
interface alu_pipe_cc_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_set_cc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [2:0]       out_flags;
    logic [2:0]       cc;
    logic [2:0]       cond_fn;
    logic             cnd;

    modport master (
        output in_valid, in_op, in_a, in_b, in_set_cc, out_ready, cond_fn,
        input  in_ready, out_valid, out_result, out_flags, cc, cnd
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_set_cc, out_ready, cond_fn,
        output in_ready, out_valid, out_result, out_flags, cc, cnd
    );
endinterface

// File: rtl/alu_pipe_cc.sv
// Two-stage pipelined ALU (add/sub/and/xor) producing {ZF,SF,OF} flags per result.
// Define ALU_PIPE_CC_CC_EN to build the condition-code register and the cnd evaluator.
module alu_pipe_cc #(
    parameter int WIDTH = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_pipe_cc_if.slave  bus
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] w_result;
    logic             w_of;
    logic [2:0]       w_flags;
    logic             w_s2Fire;
    logic             w_s1Advance;
    logic             w_inReady;
    logic             w_accept;

    logic             r_s1Valid;
    logic [WIDTH-1:0] r_s1Result;
    logic [2:0]       r_s1Flags;
    logic             r_s1SetCc;
    logic             r_s2Valid;
    logic [WIDTH-1:0] r_s2Result;
    logic [2:0]       r_s2Flags;

    always_comb begin
        w_result = '0;
        w_of     = 1'b0;
        case (bus.in_op)
            2'b00: begin
                w_result = bus.in_a + bus.in_b;
                w_of     = (bus.in_a[MSB] == bus.in_b[MSB]) & (w_result[MSB] != bus.in_a[MSB]);
            end
            2'b01: begin
                w_result = bus.in_a - bus.in_b;
                w_of     = (bus.in_a[MSB] != bus.in_b[MSB]) & (w_result[MSB] != bus.in_a[MSB]);
            end
            2'b10:   w_result = bus.in_a & bus.in_b;
            default: w_result = bus.in_a ^ bus.in_b;
        endcase
        w_flags = {(w_result == '0), w_result[MSB], w_of};
    end

    // in_ready depends only on pipeline state, never on in_valid.
    assign w_s2Fire    = r_s2Valid & bus.out_ready;
    assign w_s1Advance = r_s1Valid & (~r_s2Valid | w_s2Fire);
    assign w_inReady   = ~r_s1Valid | w_s1Advance;
    assign w_accept    = bus.in_valid & w_inReady;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1Valid  <= 1'b0;
            r_s1Result <= '0;
            r_s1Flags  <= '0;
            r_s1SetCc  <= 1'b0;
        end else if (w_accept) begin
            r_s1Valid  <= 1'b1;
            r_s1Result <= w_result;
            r_s1Flags  <= w_flags;
            r_s1SetCc  <= bus.in_set_cc;
        end else if (w_s1Advance) begin
            r_s1Valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2Valid  <= 1'b0;
            r_s2Result <= '0;
            r_s2Flags  <= '0;
        end else if (w_s1Advance) begin
            r_s2Valid  <= 1'b1;
            r_s2Result <= r_s1Result;
            r_s2Flags  <= r_s1Flags;
        end else if (w_s2Fire) begin
            r_s2Valid  <= 1'b0;
        end
    end

    assign bus.in_ready   = w_inReady;
    assign bus.out_valid  = r_s2Valid;
    assign bus.out_result = r_s2Result;
    assign bus.out_flags  = r_s2Flags;

`ifdef ALU_PIPE_CC_CC_EN
    logic [2:0] r_cc;
    logic       w_cnd;
    logic       w_zf;
    logic       w_lt;

    // cc follows a transaction only when it leaves S1, so discarded work never touches it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cc <= '0;
        end else if (w_s1Advance && r_s1SetCc) begin
            r_cc <= r_s1Flags;
        end
    end

    assign w_zf = r_cc[2];
    assign w_lt = r_cc[1] ^ r_cc[0];

    always_comb begin
        w_cnd = 1'b0;
        case (bus.cond_fn)
            3'd0:    w_cnd = 1'b1;
            3'd1:    w_cnd = w_lt | w_zf;
            3'd2:    w_cnd = w_lt;
            3'd3:    w_cnd = w_zf;
            3'd4:    w_cnd = ~w_zf;
            3'd5:    w_cnd = ~w_lt;
            3'd6:    w_cnd = ~w_lt & ~w_zf;
            default: w_cnd = 1'b0;
        endcase
    end

    assign bus.cc  = r_cc;
    assign bus.cnd = w_cnd;
`else
    logic w_unusedSetCc;
    assign w_unusedSetCc = r_s1SetCc;
    assign bus.cc        = 3'b000;
    assign bus.cnd       = (bus.cond_fn == 3'd0);
`endif
endmodule

// File: tb/tb_alu_pipe_cc.sv
// Scoreboard bench for alu_pipe_cc: a 64-bit instance for the main scenarios and an
// 8-bit instance for narrow-width flag corners. cc expectations follow ALU_PIPE_CC_CC_EN.
`timescale 1ns/100ps
module tb_alu_pipe_cc;
    logic clk;
    logic rst_n;

    alu_pipe_cc_if #(.WIDTH(64)) bus ();
    alu_pipe_cc_if #(.WIDTH(8))  bus8 ();

    alu_pipe_cc #(.WIDTH(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_pipe_cc #(.WIDTH(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int vectors = 0;
    int miscompares = 0;
    logic [66:0] sb[$];
    logic [2:0]  expCc = 3'b000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: sign-extend into one spare bit; overflow shows as the top two bits disagreeing.
    function automatic logic [66:0] model64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        logic [63:0] r;
        logic        of;
        s  = '0;
        r  = '0;
        of = 1'b0;
        case (op)
            2'b00: begin s = {a[63], a} + {b[63], b}; r = s[63:0]; of = s[64] ^ s[63]; end
            2'b01: begin s = {a[63], a} - {b[63], b}; r = s[63:0]; of = s[64] ^ s[63]; end
            2'b10: r = a & b;
            default: r = a ^ b;
        endcase
        return {r, (r == 64'd0), r[63], of};
    endfunction

    function automatic logic exp_cnd(input logic [2:0] c, input logic [2:0] fn);
`ifdef ALU_PIPE_CC_CC_EN
        logic zf, sf, of;
        zf = c[2]; sf = c[1]; of = c[0];
        case (fn)
            3'd0: return 1'b1;
            3'd1: return (sf != of) || zf;
            3'd2: return (sf != of);
            3'd3: return zf;
            3'd4: return !zf;
            3'd5: return (sf == of);
            3'd6: return (sf == of) && !zf;
            default: return 1'b0;
        endcase
`else
        return (c == 3'b000) && (fn == 3'd0);
`endif
    endfunction

    // Scoreboard: push on each accepted operation, pop and compare on each consumed result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL sb_unexpected: got result %h flags %b, expected no output", bus.out_result, bus.out_flags);
                end else begin
                    logic [66:0] e;
                    e = sb.pop_front();
                    if ({bus.out_result, bus.out_flags} !== e) begin
                        miscompares++;
                        $display("[TB] FAIL sb_result: got %h/%b, expected %h/%b", bus.out_result, bus.out_flags, e[66:3], e[2:0]);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model64(bus.in_op, bus.in_a, bus.in_b));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic setCc);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_set_cc = setCc;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_set_cc = 1'b0;
    endtask

    task automatic wait_drain(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !bus.out_valid) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        bus.out_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
        vectors++; if (bus.out_result !== 64'd0) begin miscompares++; $display("[TB] FAIL reset_out_result: got %h, expected 0", bus.out_result); end
        vectors++; if (bus.out_flags !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_out_flags: got %b, expected 000", bus.out_flags); end
        vectors++; if (bus.cc !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_cc: got %b, expected 000", bus.cc); end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
    endtask

    task automatic test_overflow_add();
        step();
        drive(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_in_ready: got %b, expected 1", bus.in_ready); end
        step();
        idle();
        @(negedge clk);
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_early_valid: got %b, expected 0", bus.out_valid); end
        step();
`ifdef ALU_PIPE_CC_CC_EN
        expCc = 3'b011;
`endif
        @(negedge clk);
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_latency: got out_valid %b, expected 1", bus.out_valid); end
        vectors++; if (bus.out_result !== 64'h8000_0000_0000_0000) begin miscompares++; $display("[TB] FAIL ovf_result: got %h, expected 8000000000000000", bus.out_result); end
        vectors++; if (bus.out_flags !== 3'b011) begin miscompares++; $display("[TB] FAIL ovf_flags: got %b, expected 011", bus.out_flags); end
        vectors++; if (bus.cc !== expCc) begin miscompares++; $display("[TB] FAIL ovf_cc: got %b, expected %b", bus.cc, expCc); end
        step();
        for (int f = 0; f < 8; f++) begin
            bus.cond_fn = f[2:0];
            #1;
            vectors++;
            if (bus.cnd !== exp_cnd(expCc, f[2:0])) begin
                miscompares++;
                $display("[TB] FAIL ovf_cnd_%0d: got %b, expected %b", f, bus.cnd, exp_cnd(expCc, f[2:0]));
            end
        end
        bus.cond_fn = 3'd0;
    endtask

    task automatic test_sub_xor();
        logic ok;
        step();
        drive(2'b01, 64'd5, 64'd5, 1'b1);
        step();
        drive(2'b11, 64'hF0, 64'h0F, 1'b0);
        step();
        idle();
        wait_drain(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL subxor_drain: got %0d pending, expected 0", sb.size()); end
`ifdef ALU_PIPE_CC_CC_EN
        expCc = 3'b100;
`endif
        step();
        bus.cond_fn = 3'd3;
        #1;
        vectors++; if (bus.cc !== expCc) begin miscompares++; $display("[TB] FAIL subxor_cc: got %b, expected %b", bus.cc, expCc); end
        vectors++; if (bus.cnd !== exp_cnd(expCc, 3'd3)) begin miscompares++; $display("[TB] FAIL subxor_cnd: got %b, expected %b", bus.cnd, exp_cnd(expCc, 3'd3)); end
        bus.cond_fn = 3'd0;
    endtask

    task automatic test_backpressure();
        logic [1:0]  ops[4];
        logic [63:0] as[4];
        logic [63:0] bs[4];
        logic [66:0] e0;
        logic        ok;
        int          accepted;
        ops = '{2'b00, 2'b01, 2'b10, 2'b11};
        as  = '{64'd100, 64'd3, 64'hFF00, 64'h1234};
        bs  = '{64'd23, 64'd10, 64'h0FF0, 64'h1234};
        e0  = model64(ops[0], as[0], bs[0]);
        accepted = 0;
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(ops[accepted], as[accepted], bs[accepted], 1'b0);
            @(negedge clk);
            vectors++;
            if (bus.in_ready !== (i < 2)) begin miscompares++; $display("[TB] FAIL bp_in_ready_%0d: got %b, expected %b", i, bus.in_ready, (i < 2)); end
            if (bus.in_ready) accepted++;
            if (i >= 2) begin
                vectors++;
                if ({bus.out_valid, bus.out_result, bus.out_flags} !== {1'b1, e0}) begin
                    miscompares++;
                    $display("[TB] FAIL bp_hold_%0d: got %b/%h/%b, expected 1/%h/%b", i, bus.out_valid, bus.out_result, bus.out_flags, e0[66:3], e0[2:0]);
                end
            end
            step();
        end
        vectors++; if (accepted !== 2) begin miscompares++; $display("[TB] FAIL bp_accepted: got %0d, expected 2", accepted); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (accepted < 4) drive(ops[accepted], as[accepted], bs[accepted], 1'b0);
            else idle();
            @(negedge clk);
            vectors++;
            if (bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_stream_%0d: got out_valid %b, expected 1", i, bus.out_valid); end
            if (bus.in_valid && bus.in_ready) accepted++;
            step();
        end
        idle();
        wait_drain(ok);
        vectors++; if (ok !== 1'b1 || accepted !== 4) begin miscompares++; $display("[TB] FAIL bp_drain: got %0d accepted %0d pending, expected 4 and 0", accepted, sb.size()); end
    endtask

    task automatic test_reset_midflight();
        step();
        bus.out_ready = 1'b0;
        drive(2'b01, 64'd9, 64'd9, 1'b1);
        step();
        drive(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        step();
        idle();
`ifdef ALU_PIPE_CC_CC_EN
        expCc = 3'b100;
`endif
        @(negedge clk);
        vectors++; if ({bus.out_valid, bus.in_ready} !== 2'b10) begin miscompares++; $display("[TB] FAIL mid_full: got valid/ready %b%b, expected 10", bus.out_valid, bus.in_ready); end
        vectors++; if (bus.cc !== expCc) begin miscompares++; $display("[TB] FAIL mid_cc_before: got %b, expected %b", bus.cc, expCc); end
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sb.delete();
        expCc = 3'b000;
        @(negedge clk);
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_out_valid: got %b, expected 0", bus.out_valid); end
        vectors++; if (bus.cc !== 3'b000) begin miscompares++; $display("[TB] FAIL mid_cc: got %b, expected 000", bus.cc); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_in_ready: got %b, expected 1", bus.in_ready); end
        step();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.out_valid !== 1'b0 || bus.cc !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL mid_stale_%0d: got out_valid %b cc %b, expected 0 and 000", i, bus.out_valid, bus.cc);
            end
            step();
        end
    endtask

    task automatic test_width_edges();
        logic ok;
        step();
        drive(2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        step();
        idle();
        step();
        @(negedge clk);
        vectors++;
        if ({bus.out_valid, bus.out_result, bus.out_flags} !== {1'b1, 64'h8000_0000_0000_0000, 3'b010}) begin
            miscompares++;
            $display("[TB] FAIL and64: got %b/%h/%b, expected 1/8000000000000000/010", bus.out_valid, bus.out_result, bus.out_flags);
        end
        wait_drain(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL and64_drain: got %0d pending, expected 0", sb.size()); end
        step();
        bus8.in_valid = 1'b1; bus8.in_op = 2'b01; bus8.in_a = 8'h80; bus8.in_b = 8'h01;
        step();
        bus8.in_valid = 1'b1; bus8.in_op = 2'b00; bus8.in_a = 8'h7F; bus8.in_b = 8'h01;
        step();
        bus8.in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus8.out_valid, bus8.out_result, bus8.out_flags} !== {1'b1, 8'h7F, 3'b001}) begin
            miscompares++;
            $display("[TB] FAIL sub8: got %b/%h/%b, expected 1/7f/001", bus8.out_valid, bus8.out_result, bus8.out_flags);
        end
        step();
        @(negedge clk);
        vectors++;
        if ({bus8.out_valid, bus8.out_result, bus8.out_flags} !== {1'b1, 8'h80, 3'b011}) begin
            miscompares++;
            $display("[TB] FAIL add8: got %b/%h/%b, expected 1/80/011", bus8.out_valid, bus8.out_result, bus8.out_flags);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic ok;
        int   sent;
        int   budget;
        step();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
            @(negedge clk);
            vectors++;
            if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ready_%0d: got %b, expected 1", i, bus.in_ready); end
            step();
        end
        sent = 0;
        budget = 0;
        drive(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        while (sent < 20 && budget < 300) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.in_ready) begin
                sent++;
                step();
                drive(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
            end else begin
                step();
            end
            budget++;
        end
        idle();
        bus.out_ready = 1'b1;
        vectors++; if (sent !== 20) begin miscompares++; $display("[TB] FAIL b2b_sent: got %0d, expected 20", sent); end
        wait_drain(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_drain: got %0d pending, expected 0", sb.size()); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_a = '0; bus.in_b = '0;
        bus.in_set_cc = 1'b0; bus.out_ready = 1'b1; bus.cond_fn = 3'd0;
        bus8.in_valid = 1'b0; bus8.in_op = 2'b00; bus8.in_a = '0; bus8.in_b = '0;
        bus8.in_set_cc = 1'b0; bus8.out_ready = 1'b1; bus8.cond_fn = 3'd0;
        test_reset();
        test_overflow_add();
        test_sub_xor();
        test_backpressure();
        test_reset_midflight();
        test_width_edges();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        miscompares++;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
